// File: rtl/pipelined_adder_if.sv
// Handshake bundle for pipelined_adder: operation in, result out.
// Producer drives through master, the adder consumes through slave.
interface pipelined_adder_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] addSum;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, inA, inB, cin, sub,
    output out_ready,
    input  in_ready, out_valid, addSum,
    input  cout, overflow, zero, negative
  );

  modport slave (
    input  in_valid, inA, inB, cin, sub,
    input  out_ready,
    output in_ready, out_valid, addSum,
    output cout, overflow, zero, negative
  );
endinterface

// File: rtl/pipelined_adder.sv
// Skewed add/sub pipeline, one SW-bit carry-linked slice per stage.
// Define PIPE_ADDER_FLAGS_EN to build overflow/zero/negative flags.
module pipelined_adder #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              reset,
  pipelined_adder_if.slave  bus
);
  localparam int SW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] nv;
  logic [STAGES-1:0] rc;
  logic [STAGES-1:0] sc;
  logic [STAGES-1:0] nc;
  logic [WIDTH-1:0]  ra [STAGES];
  logic [WIDTH-1:0]  rb [STAGES];
  logic [WIDTH-1:0]  rs [STAGES];
  logic [WIDTH-1:0]  sa [STAGES];
  logic [WIDTH-1:0]  sb [STAGES];
  logic [WIDTH-1:0]  ss [STAGES];
  logic [WIDTH-1:0]  ns [STAGES];
  logic [SW:0]       part;
  logic              go;

  assign bus.in_ready  = !v[L] || bus.out_ready;
  assign bus.out_valid = v[L];
  assign bus.addSum    = rs[L];
  assign bus.cout      = rc[L];

  // A stage loads when empty or when the stage after it loads.
  always_comb begin
    ld    = '0;
    go    = !v[L] || bus.out_ready;
    ld[L] = go;
    for (int k = L - 1; k >= 0; k--) begin
      go    = !v[k] || go;
      ld[k] = go;
    end
  end

  always_comb begin
    sa[0] = bus.inA;
    sb[0] = bus.sub ? ~bus.inB : bus.inB;
    sc[0] = bus.sub | bus.cin;
    ss[0] = '0;
    nv[0] = bus.in_valid && bus.in_ready;
    for (int k = 1; k < STAGES; k++) begin
      sa[k] = ra[k-1];
      sb[k] = rb[k-1];
      sc[k] = rc[k-1];
      ss[k] = rs[k-1];
      nv[k] = v[k-1];
    end
  end

  always_comb begin
    part = '0;
    nc   = '0;
    ns   = ss;
    for (int k = 0; k < STAGES; k++) begin
      part = {1'b0, sa[k][k*SW +: SW]}
           + {1'b0, sb[k][k*SW +: SW]}
           + {{SW{1'b0}}, sc[k]};
      ns[k][k*SW +: SW] = part[SW-1:0];
      nc[k] = part[SW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v  <= '0;
      rc <= '0;
      for (int k = 0; k < STAGES; k++) begin
        ra[k] <= '0;
        rb[k] <= '0;
        rs[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          v[k]  <= nv[k];
          ra[k] <= sa[k];
          rb[k] <= sb[k];
          rs[k] <= ns[k];
          rc[k] <= nc[k];
        end
      end
    end
  end

`ifdef PIPE_ADDER_FLAGS_EN
  logic rovf;
  logic rzero;
  logic rneg;
  logic msb_cin;

  // Carry into the MSB recovered from the MSB sum bit.
  assign msb_cin = sa[L][WIDTH-1] ^ sb[L][WIDTH-1]
                 ^ ns[L][WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      rovf  <= 1'b0;
      rzero <= 1'b0;
      rneg  <= 1'b0;
    end else if (ld[L]) begin
      rovf  <= msb_cin ^ nc[L];
      rzero <= (ns[L] == '0);
      rneg  <= ns[L][WIDTH-1];
    end
  end

  assign bus.overflow = rovf;
  assign bus.zero     = rzero;
  assign bus.negative = rneg;
`else
  assign bus.overflow = 1'b0;
  assign bus.zero     = 1'b0;
  assign bus.negative = 1'b0;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: scoreboard of arithmetic results,
// directed corner cases, stall, mid-flight reset and random traffic.
module tb_pipelined_adder;
  localparam int W = 64;
  localparam int S = 4;
`ifdef PIPE_ADDER_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
    logic         z;
    logic         n;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pipelined_adder_if #(.WIDTH(W)) bus();

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_stall = -1;
  int   n_acc = 0;
  exp_t q[$];

  task automatic chk(string nm, logic [W-1:0] act,
                     logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(logic [W-1:0] a,
                                 logic [W-1:0] b,
                                 logic c, logic s);
    exp_t e;
    logic [W:0] t;
    if (s) begin
      e.sum = a - b;
      e.co  = (a >= b);
      e.ov  = (a[W-1] != b[W-1]) && (e.sum[W-1] != a[W-1]);
    end else begin
      t     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      e.sum = t[W-1:0];
      e.co  = t[W];
      e.ov  = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
    end
    e.z   = FL && (e.sum == '0);
    e.n   = FL && e.sum[W-1];
    e.ov  = FL && e.ov;
    e.acc = 0;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    case ($urandom_range(0, 5))
      0:       r = '1;
      1:       r = '0;
      2:       r = {1'b0, {(W-1){1'b1}}};
      3:       r = {1'b1, {(W-1){1'b0}}};
      default: r = {$urandom, $urandom};
    endcase
    return r;
  endfunction

  // Handshake monitor: push on accept, pop on result transfer.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      q.delete();
    end else begin
      if (!bus.out_ready) last_stall = cyc;
      if (bus.out_valid && bus.out_ready && q.size() > 0)
        void'(q.pop_front());
      if (bus.in_valid && bus.in_ready) begin
        e = model(bus.inA, bus.inB, bus.cin, bus.sub);
        e.acc = cyc;
        q.push_back(e);
        n_acc++;
      end
    end
  end

  // Per-cycle compare against the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      chk("in_ready", bus.in_ready,
          !bus.out_valid || bus.out_ready);
      if (q.size() == 0) begin
        chk("idle out_valid", bus.out_valid, 0);
      end else begin
        if (cyc < q[0].acc + S - 1)
          chk("early out_valid", bus.out_valid, 0);
        else if (cyc == q[0].acc + S - 1 &&
                 last_stall <= q[0].acc)
          chk("latency out_valid", bus.out_valid, 1);
        if (bus.out_valid) begin
          chk("addSum", bus.addSum, q[0].sum);
          chk("cout", bus.cout, q[0].co);
          chk("overflow", bus.overflow, q[0].ov);
          chk("zero", bus.zero, q[0].z);
          chk("negative", bus.negative, q[0].n);
        end
      end
    end
  end

  task automatic send(logic [W-1:0] a, logic [W-1:0] b,
                      logic c, logic s);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.inA = a;
    bus.inB = b;
    bus.cin = c;
    bus.sub = s;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk);
      ok = bus.in_ready;
    end
    if (!ok) chk("send timeout", 0, 1);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic directed(string nm,
                          logic [W-1:0] a, logic [W-1:0] b,
                          logic c, logic s,
                          logic [W-1:0] xs, logic xc,
                          logic xo, logic xz, logic xn);
    int n;
    n = 0;
    send(a, b, c, s);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (bus.out_valid) break;
    end
    chk({nm, " latency"}, n, S);
    chk({nm, " sum"}, bus.addSum, xs);
    chk({nm, " cout"}, bus.cout, xc);
    chk({nm, " ovf"}, bus.overflow, xo & FL);
    chk({nm, " zero"}, bus.zero, xz & FL);
    chk({nm, " neg"}, bus.negative, xn & FL);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(string nm);
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0 && !bus.out_valid) break;
      @(negedge clk);
    end
    chk(nm, q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int start;
    bus.in_valid  = 1'b0;
    bus.inA       = '0;
    bus.inB       = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst in_ready", bus.in_ready, 1);
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst addSum", bus.addSum, 0);
    chk("rst cout", bus.cout, 0);
    chk("rst ovf", bus.overflow, 0);
    chk("rst zero", bus.zero, 0);
    chk("rst neg", bus.negative, 0);
    @(posedge clk);
    #1;

    directed("add small", 64'd454, 64'd6969, 1'b0, 1'b0,
             64'd7423, 1'b0, 1'b0, 1'b0, 1'b0);
    directed("carry chain", 64'hFFFF_FFFF_FFFF_FFFF,
             64'd200, 1'b0, 1'b0,
             64'd199, 1'b1, 1'b0, 1'b0, 1'b0);
    directed("signed ovf", 64'h7FFF_FFFF_FFFF_FFFF,
             64'd1, 1'b0, 1'b0,
             64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    directed("sub zero", 64'd5, 64'd5, 1'b0, 1'b1,
             64'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    directed("add cin", 64'd10, 64'd20, 1'b1, 1'b0,
             64'd31, 1'b0, 1'b0, 1'b0, 1'b0);

    // Eight back-to-back ops with a 6-cycle consumer stall.
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(rnd(), rnd(), 1'($urandom), 1'($urandom));
      end
      begin
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        for (int j = 0; j < 6; j++) begin
          @(negedge clk);
          if (j == 3 || j == 5) begin
            chk("stall in_ready", bus.in_ready, 0);
            chk("stall occupancy", q.size(), S);
          end
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain("stall drain");

    // Reset with three tokens in flight.
    for (int i = 0; i < 3; i++)
      send(rnd(), rnd(), 1'($urandom), 1'($urandom));
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post-reset out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    directed("after reset", 64'd1000, 64'd24, 1'b0, 1'b0,
             64'd1024, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic with random backpressure.
    start = n_acc;
    for (int i = 0; i < 6000 && n_acc - start < 1000; i++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.inA       = rnd();
      bus.inB       = rnd();
      bus.cin       = 1'($urandom);
      bus.sub       = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 8);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("random accepted", n_acc - start, 1000);
    bus.out_ready = 1'b1;
    drain("random drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined add/subtract unit that splits a WIDTH-bit operation into STAGES equal carry-linked slices, one slice per clock. It accepts one operation per cycle through a valid/ready handshake and returns the sum with carry-out and status flags STAGES cycles later. It sits between the register-read stage and the writeback mux as the multi-cycle replacement for the single-cycle ripple adder on wide datapaths.

## Interface
- WIDTH, 64, operand/result width in bits; WIDTH % STAGES must be 0.
- STAGES, 4, pipeline depth and slice count; 1 ≤ STAGES ≤ WIDTH; slice width SW = WIDTH/STAGES.

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  unit can accept this cycle.
- inA  input  WIDTH  operand A.
- inB  input  WIDTH  operand B.
- cin  input  1  carry-in, used for add only.
- sub  input  1  1 = A − B, 0 = A + B + cin.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.
- addSum  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH−1 (for sub: 1 = no borrow).
- overflow  output  1  signed overflow.
- zero  output  1  addSum == 0.
- negative  output  1  addSum[WIDTH−1].

## Operation
- Accept: transfer when in_valid && in_ready. Captured into stage 0: A, B' = sub ? ~inB : inB, c0 = sub ? 1 : cin.
- Stage k (0..STAGES−1) adds slice k: A[k*SW +: SW] + B'[k*SW +: SW] + carry from stage k−1 register (c0 for k=0). Result slice and carry registered; unconsumed upper operand slices and completed lower sum slices travel with the token (skewed pipeline).
- Overflow at final stage: carry into MSB XOR carry out of MSB.
- zero and negative computed from the fully assembled final sum.
- Each stage holds a valid bit; stage advances when its downstream slot is empty or advancing.
- Stall: in_ready = !v[last] || out_ready, with bubbles collapsing: stage k loads when !v[k] or stage k+1 loads. Holding a token keeps all its data stable.
- Result: out_valid = v[last]; addSum/cout/flags are the last-stage registers; stable while out_valid && !out_ready.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- Reset: all valid bits 0, in_ready = 1, out_valid = 0, addSum = 0, cout = overflow = zero = negative = 0.
- Latency: operation accepted at edge N appears with out_valid = 1 after edge N+STAGES−1 (visible in cycle N+STAGES−1 following the accept edge; STAGES=1 → result registered at accept edge).
- Throughput: 1 op/cycle while out_ready = 1.
- Full pipeline with out_ready = 0: in_ready = 0 until the last stage drains; no data lost or duplicated.
- Simultaneous accept and output handshake in same cycle when full: allowed, pipeline shifts by one.
- Reset asserted mid-operation: all in-flight tokens discarded at that edge; no result emitted for them.
- in_valid low: bubble propagates; outputs hold last data with out_valid = 0 semantics only (data bits are don't-care to consumer).

## Configuration
- PIPE_ADDER_FLAGS_EN defined: overflow, zero, negative generated as above.
- Not defined: overflow, zero, negative tied to 0, no flag logic or registers; addSum, cout, handshake and latency unchanged.

## Test plan
- WIDTH=64, STAGES=4, out_ready=1: inA=454, inB=6969, sub=0, cin=0 -> addSum=7423, cout=0, zero=0, out_valid exactly 4 cycles after accept.
- inA=64'hFFFF_FFFF_FFFF_FFFF, inB=200, add -> addSum=199, cout=1, overflow=0; carry crosses all 4 slices correctly.
- inA=64'h7FFF_FFFF_FFFF_FFFF, inB=1, add -> addSum=64'h8000_0000_0000_0000, overflow=1, negative=1; inA=5, inB=5, sub=1 -> addSum=0, zero=1, cout=1.
- Back-to-back 8 ops, out_ready held 0 for 6 cycles mid-stream -> in_ready drops when 4 ops stored, all 8 results emerge in order, none duplicated, data stable during stall.
- Reset asserted for 1 cycle with 3 tokens in flight -> out_valid = 0 next cycle, no stale result emitted, next op after reset has correct 4-cycle latency.
- Rebuild without PIPE_ADDER_FLAGS_EN, and with STAGES=1 and STAGES=64 -> flags 0, sums/cout match reference model over 1000 random vectors, latency = STAGES.
